// File: rtl/fb_write_if.sv
// Pixel and framebuffer-link bundle used by fb_write_scheduler.
// Two signal groups travel together:
//   pixel side : pixel_in / pixel_valid (into the scheduler), pixel_ready (out)
//   link side  : write_data_in / reset_write_ptr / write_data (out), wrote_data echo (in)
// The master modport is the scheduler's view. The slave modport is the view of the
// compute core plus the framebuffer driver.
interface fb_write_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] pixel_in;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [DATA_W-1:0] write_data_in;
  logic              reset_write_ptr;
  logic              write_data;
  logic              wrote_data;

  modport master (
    input  pixel_in, pixel_valid, wrote_data,
    output pixel_ready, write_data_in, reset_write_ptr, write_data
  );

  modport slave (
    output pixel_in, pixel_valid, wrote_data,
    input  pixel_ready, write_data_in, reset_write_ptr, write_data
  );
endinterface

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
// Takes pixels from the compute core through a small FIFO. It writes them to the
// QSPI framebuffer link as strobes, and the link echoes each strobe back to confirm it.
// Every frame starts by resetting the framebuffer write pointer. Each pixel is then
// strobed: write_data is held high until the echo goes high, then held low until the
// echo goes low again.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   frame_start    : one-cycle request to begin or restart a frame
//   link           : pixel valid/ready input plus framebuffer link (fb_write_if.master)
//   busy           : a frame is in progress
//   frame_done     : one-cycle pulse when the last pixel of the frame is confirmed
//   link_error     : sticky flag for an echo timeout; cleared by frame_start or rst
//   pixels_written : number of confirmed pixels in the current frame
module fb_write_scheduler #(
  parameter int FRAME_PIXELS     = 76800,
  parameter int FIFO_DEPTH       = 4,
  parameter int WRITE_HOLD       = 2,
  parameter int WRITE_GAP        = 2,
  parameter int PTR_RESET_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int DATA_W           = 4,
  localparam int CW              = $clog2(FRAME_PIXELS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  fb_write_if.master    link,
  output logic          busy,
  output logic          frame_done,
  output logic          link_error,
  output logic [CW-1:0] pixels_written
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + PTR_RESET_CYCLES + WRITE_HOLD + WRITE_GAP + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PTR_RST = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_STB_HI  = 3'd3;
  localparam logic [2:0] S_STB_LO  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [TW-1:0] PTR_LAST  = TW'(PTR_RESET_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(WRITE_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(WRITE_GAP - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX   = '1;
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_PIXELS);
  localparam logic [AW:0]   FIFO_CAP  = (AW + 1)'(FIFO_DEPTH);

  // Pixel counters stop at FRAME_PIXELS instead of wrapping around.
  function automatic logic [CW-1:0] sat_inc_px(input logic [CW-1:0] v);
    return (v >= FRAME_CNT) ? FRAME_CNT : v + 1'b1;
  endfunction

  // The state timer stops at all-ones, so a long IDLE/DONE cannot wrap it.
  function automatic logic [TW-1:0] sat_inc_tmr(input logic [TW-1:0] v);
    return (v == TMR_MAX) ? v : v + 1'b1;
  endfunction

  logic [2:0]        state;
  logic [TW-1:0]     tmr;          // cycles spent in the current state, 0 on entry
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fcnt;
  logic [CW-1:0]     accepted;
  logic [DATA_W-1:0] wdata;

  logic fifo_empty, fifo_full, push, pop, hi_done, lo_done, timeout;
  logic [CW-1:0] pw_next;

  assign fifo_empty = (fcnt == '0);
  assign fifo_full  = (fcnt == FIFO_CAP);

  assign busy = (state == S_PTR_RST) || (state == S_FETCH) ||
                (state == S_STB_HI)  || (state == S_STB_LO);

  // pixel_ready is gated by frame_start. A pixel offered in the restart cycle would
  // be flushed anyway, so it is not acknowledged.
  assign link.pixel_ready = busy && (state != S_PTR_RST) && !fifo_full &&
                            (accepted < FRAME_CNT) && !frame_start;
  assign link.reset_write_ptr = (state == S_PTR_RST);
  assign link.write_data      = (state == S_STB_HI);
  assign link.write_data_in   = wdata;

  assign push = link.pixel_valid && link.pixel_ready;
  // fcnt only counts entries pushed in earlier cycles, so a pop never returns
  // data pushed in the same cycle.
  assign pop  = (state == S_FETCH) && !fifo_empty && !frame_start;

  assign hi_done = (tmr >= HOLD_LAST) && link.wrote_data;
  assign lo_done = (tmr >= GAP_LAST) && !link.wrote_data;
  assign timeout = ((state == S_STB_HI) && !hi_done && (tmr >= TO_LAST)) ||
                   ((state == S_STB_LO) && !lo_done && (tmr >= TO_LAST));
  assign pw_next = sat_inc_px(pixels_written);

  // FIFO storage holds no control state, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= link.pixel_in;
    end
  end

  // FIFO pointers and the accept count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      accepted <= '0;
    end else if (frame_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      accepted <= '0;
    end else if (timeout) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= sat_inc_px(accepted);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Frame sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tmr            <= '0;
      wdata          <= '0;
      pixels_written <= '0;
      link_error     <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      tmr        <= sat_inc_tmr(tmr);
      if (frame_start) begin
        state          <= S_PTR_RST;
        tmr            <= '0;
        wdata          <= '0;
        pixels_written <= '0;
        link_error     <= 1'b0;
      end else begin
        case (state)
          S_PTR_RST: begin
            if (tmr >= PTR_LAST) begin
              state <= S_FETCH;
              tmr   <= '0;
            end
          end
          S_FETCH: begin
            if (pop) begin
              wdata <= mem[rd_ptr];
              state <= S_STB_HI;
              tmr   <= '0;
            end
          end
          S_STB_HI: begin
            if (hi_done) begin
              state <= S_STB_LO;
              tmr   <= '0;
            end else if (timeout) begin
              link_error <= 1'b1;
              wdata      <= '0;
              state      <= S_IDLE;
              tmr        <= '0;
            end
          end
          S_STB_LO: begin
            if (lo_done) begin
              pixels_written <= pw_next;
              wdata          <= '0;
              tmr            <= '0;
              if (pw_next == FRAME_CNT) begin
                state      <= S_DONE;
                frame_done <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end else if (timeout) begin
              link_error <= 1'b1;
              wdata      <= '0;
              state      <= S_IDLE;
              tmr        <= '0;
            end
          end
          default: begin
            // IDLE and DONE wait for frame_start.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Testbench for fb_write_scheduler, built with FRAME_PIXELS=4.
// A reference model records every accepted pixel in a queue. Each write_data rising
// edge must present the oldest pixel still in the queue. The model also measures
// strobe high and low widths and counts frame_done cycles.
module tb_fb_write_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       busy, frame_done, link_error;
  logic [2:0] pw;
  logic       stall;
  logic       echo_q = 1'b0;

  fb_write_if #(.DATA_W(4)) bus ();

  fb_write_scheduler #(
    .FRAME_PIXELS(4), .FIFO_DEPTH(4), .WRITE_HOLD(2), .WRITE_GAP(2),
    .PTR_RESET_CYCLES(4), .TIMEOUT_CYCLES(64), .DATA_W(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .link(bus),
    .busy(busy), .frame_done(frame_done), .link_error(link_error),
    .pixels_written(pw)
  );

  always #5 clk = ~clk;

  // Framebuffer driver: echoes write_data one cycle later, or holds the echo at 0.
  always @(posedge clk) echo_q <= bus.write_data;
  assign bus.wrote_data = stall ? 1'b0 : echo_q;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [3:0] exp_q[$];
  int   strobes = 0, fd_cycles = 0, acc_cnt = 0, hi_len = 0, lo_len = 0;
  logic prev_wd = 1'b0;
  bit   seen_fall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_wd   = 1'b0;
      hi_len    = 0;
      lo_len    = 0;
      seen_fall = 1'b0;
    end else begin
      if (bus.pixel_valid && bus.pixel_ready) begin
        exp_q.push_back(bus.pixel_in);
        acc_cnt++;
      end
      if (frame_done) fd_cycles++;
      if (bus.write_data && !prev_wd) begin
        logic [3:0] e;
        strobes++;
        if (seen_fall) check("strobe_gap_ge2", 32'(lo_len >= 2), 32'd1);
        if (exp_q.size() == 0) begin
          check("extra_strobe_qsize", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pixel_order", 32'(bus.write_data_in), 32'(e));
        end
        hi_len = 1;
      end else if (bus.write_data) begin
        hi_len++;
      end else if (prev_wd) begin
        check("strobe_hold_ge2", 32'(hi_len >= 2), 32'd1);
        lo_len    = 1;
        seen_fall = 1'b1;
      end else begin
        lo_len++;
      end
      prev_wd = bus.write_data;
    end
  end

  task automatic start_frame();
    bus.pixel_valid = 1'b0;
    frame_start = 1'b1;
    exp_q.delete();
    acc_cnt   = 0;
    strobes   = 0;
    fd_cycles = 0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic push_px(input logic [3:0] v, input int budget, output bit ok);
    ok = 1'b0;
    bus.pixel_in    = v;
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.pixel_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic wait_second_strobe(input string tag, input int budget);
    int n = 0;
    while (!(bus.write_data && strobes == 2) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(bus.write_data && strobes == 2), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dir_px [4];
    bit ok;
    int n, got, s0;
    dir_px[0] = 4'h3; dir_px[1] = 4'hA; dir_px[2] = 4'hF; dir_px[3] = 4'h1;

    rst = 1'b1; frame_start = 1'b0; stall = 1'b0;
    bus.pixel_valid = 1'b0; bus.pixel_in = 4'h0;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_data", 32'(bus.write_data), 32'd0);
    check("rst_ptr", 32'(bus.reset_write_ptr), 32'd0);
    check("rst_ready", 32'(bus.pixel_ready), 32'd0);
    check("rst_wdi", 32'(bus.write_data_in), 32'd0);
    check("rst_pw", 32'(pw), 32'd0);
    check("rst_err", 32'(link_error), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Write-pointer reset phase.
    start_frame();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.reset_write_ptr) begin
        n++;
        check("ptr_ready", 32'(bus.pixel_ready), 32'd0);
        check("ptr_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
    end
    check("ptr_cycles", 32'(n), 32'd4);
    check("fetch_ready", 32'(bus.pixel_ready), 32'd1);

    // Directed frame: 3, A, F, 1 over the loopback echo.
    for (int i = 0; i < 4; i++) begin
      push_px(dir_px[i], 20, ok);
      check("dir_accept", 32'(ok), 32'd1);
    end
    wait_idle("dir_finish", 300);
    check("dir_strobes", 32'(strobes), 32'd4);
    check("dir_done_pulse", 32'(fd_cycles), 32'd1);
    check("dir_pw", 32'(pw), 32'd4);
    check("dir_qempty", 32'(exp_q.size()), 32'd0);
    check("dir_err", 32'(link_error), 32'd0);

    // Random frame offering 6 pixels; only 4 may be accepted.
    start_frame();
    got = 0;
    for (int i = 0; i < 6; i++) begin
      push_px(4'($urandom), 40, ok);
      if (ok) begin
        got++;
        if (got == 4) check("cap_ready_low", 32'(bus.pixel_ready), 32'd0);
      end
    end
    check("cap_accepts", 32'(got), 32'd4);
    check("cap_model_acc", 32'(acc_cnt), 32'd4);
    wait_idle("cap_finish", 300);
    check("cap_strobes", 32'(strobes), 32'd4);
    check("cap_done_pulse", 32'(fd_cycles), 32'd1);
    check("cap_pw", 32'(pw), 32'd4);
    check("cap_ready_after", 32'(bus.pixel_ready), 32'd0);

    // Echo held at 0: the FIFO fills, then the echo timeout fires.
    stall = 1'b1;
    start_frame();
    bus.pixel_valid = 1'b1;
    n = 0;
    while (!bus.write_data && n < 100) begin
      bus.pixel_in = 4'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check("stall_strobe_seen", 32'(bus.write_data), 32'd1);
    n = 0;
    while (!link_error && n < 100) begin
      bus.pixel_in = 4'($urandom);
      @(posedge clk); #1;
      n++;
      if (n == 30) begin
        check("stall_acc", 32'(acc_cnt), 32'd4);
        check("stall_ready", 32'(bus.pixel_ready), 32'd0);
      end
    end
    bus.pixel_valid = 1'b0;
    check("timeout_cycles", 32'(n), 32'd64);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_wd", 32'(bus.write_data), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("timeout_sticky", 32'(link_error), 32'd1);
    check("timeout_no_done", 32'(fd_cycles), 32'd0);
    check("timeout_pw", 32'(pw), 32'd0);
    check("timeout_strobes", 32'(strobes), 32'd1);
    check("timeout_wdi", 32'(bus.write_data_in), 32'd0);
    exp_q.delete();
    stall = 1'b0;

    // Restart during the second strobe.
    start_frame();
    check("restart_err_clear", 32'(link_error), 32'd0);
    for (int i = 0; i < 2; i++) begin
      push_px(4'($urandom), 20, ok);
      check("abort_accept", 32'(ok), 32'd1);
    end
    wait_second_strobe("abort_reach_px2", 100);
    check("abort_pw_before", 32'(pw), 32'd1);
    start_frame();
    check("abort_wd_low", 32'(bus.write_data), 32'd0);
    check("abort_ptr", 32'(bus.reset_write_ptr), 32'd1);
    check("abort_pw", 32'(pw), 32'd0);
    check("abort_wdi", 32'(bus.write_data_in), 32'd0);
    s0 = strobes;
    repeat (10) begin @(posedge clk); #1; end
    check("abort_fifo_flushed", 32'(strobes), 32'(s0));
    for (int i = 0; i < 4; i++) begin
      push_px(4'($urandom), 20, ok);
      check("abort_refill", 32'(ok), 32'd1);
    end
    wait_idle("abort_finish", 300);
    check("abort_pw_final", 32'(pw), 32'd4);
    check("abort_done_pulse", 32'(fd_cycles), 32'd1);

    // Asynchronous reset in the middle of a strobe.
    start_frame();
    for (int i = 0; i < 2; i++) begin
      push_px(4'($urandom), 20, ok);
      check("arst_accept", 32'(ok), 32'd1);
    end
    wait_second_strobe("arst_reach_px2", 100);
    check("arst_pw_before", 32'(pw), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wd", 32'(bus.write_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wdi", 32'(bus.write_data_in), 32'd0);
    check("arst_pw", 32'(pw), 32'd0);
    check("arst_err", 32'(link_error), 32'd0);
    check("arst_ready", 32'(bus.pixel_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
